// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - multi-cycle unsigned multiply/divide unit fed by the ID/EX register
// Holds ID/EX via md_stall while iterating; result leaves as a one-cycle EX/MEM bundle.
module ex_muldiv #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_en,
    input  logic [2:0]        id_md_op,
    input  logic [DATA_W-1:0] id_md_in_0,
    input  logic [DATA_W-1:0] id_md_in_1,
    input  logic [ADDR_W-1:0] id_dst_addr,
    input  logic              id_gpr_we_,
    input  logic              flush,
    output logic              md_stall,
    output logic              ex_md_en,
    output logic [DATA_W-1:0] ex_md_result,
    output logic [ADDR_W-1:0] ex_md_dst_addr,
    output logic              ex_md_gpr_we_
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam logic [2:0] OP_MUL   = 3'd1;
    localparam logic [2:0] OP_MULHU = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_REMU  = 3'd4;
    localparam logic [5:0] LAST_STEP = 6'(DATA_W - 1);
    localparam int         RW = DATA_W + 1;

    state_t                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [2:0]            op_q, op_d;
    logic [ADDR_W-1:0]     dst_q, dst_d;
    logic                  we_q, we_d;
    logic [DATA_W-1:0]     opb_q, opb_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W:0]       rem_q, rem_d;
    logic [DATA_W-1:0]     quo_q, quo_d;
    logic                  ex_en_q, ex_en_d;
    logic [DATA_W-1:0]     ex_res_q, ex_res_d;
    logic [ADDR_W-1:0]     ex_dst_q, ex_dst_d;
    logic                  ex_we_q, ex_we_d;

    logic                  op_valid;
    logic                  accept;
    logic [DATA_W:0]       mul_sum;
    logic [DATA_W+1:0]     div_shift;
    logic                  div_ge;

    assign op_valid = (id_md_op >= OP_MUL) && (id_md_op <= OP_REMU);
    assign accept   = (state_q == S_IDLE) && id_en && op_valid && !flush;

    // Multiplier sits in the low half of acc and is consumed LSB first as acc shifts right.
    assign mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {rem_q, quo_q[DATA_W-1]};
    assign div_ge    = div_shift >= {2'b00, opb_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        dst_d    = dst_q;
        we_d     = we_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        ex_en_d  = 1'b0;
        ex_res_d = '0;
        ex_dst_d = '0;
        ex_we_d  = 1'b1;
        md_stall = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    md_stall = 1'b1;
                    cnt_d    = '0;
                    op_d     = id_md_op;
                    dst_d    = id_dst_addr;
                    we_d     = id_gpr_we_;
                    acc_d    = {{DATA_W{1'b0}}, id_md_in_1};
                    rem_d    = '0;
                    quo_d    = id_md_in_0;
                    if (id_md_op == OP_MUL || id_md_op == OP_MULHU) begin
                        state_d = S_MUL;
                        opb_d   = id_md_in_0;
                    end else begin
                        state_d = S_DIV;
                        opb_d   = id_md_in_1;
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    md_stall = 1'b1;
                    acc_d    = {mul_sum, acc_q[DATA_W-1:1]};
                    cnt_d    = cnt_q + 6'd1;
                    if (cnt_q == LAST_STEP) state_d = S_DONE;
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    // A zero divisor always compares ge, giving all-ones quotient and dividend remainder.
                    md_stall = 1'b1;
                    rem_d    = div_ge ? RW'(div_shift - {2'b00, opb_q}) : div_shift[DATA_W:0];
                    quo_d    = {quo_q[DATA_W-2:0], div_ge};
                    cnt_d    = cnt_q + 6'd1;
                    if (cnt_q == LAST_STEP) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                if (!flush) begin
                    ex_en_d  = 1'b1;
                    ex_dst_d = dst_q;
                    ex_we_d  = we_q;
                    case (op_q)
                        OP_MUL:   ex_res_d = acc_q[DATA_W-1:0];
                        OP_MULHU: ex_res_d = acc_q[2*DATA_W-1:DATA_W];
                        OP_DIVU:  ex_res_d = quo_q;
                        OP_REMU:  ex_res_d = rem_q[DATA_W-1:0];
                        default:  ex_res_d = '0;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            dst_q    <= '0;
            we_q     <= 1'b1;
            opb_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            ex_en_q  <= 1'b0;
            ex_res_q <= '0;
            ex_dst_q <= '0;
            ex_we_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            we_q     <= we_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            ex_en_q  <= ex_en_d;
            ex_res_q <= ex_res_d;
            ex_dst_q <= ex_dst_d;
            ex_we_q  <= ex_we_d;
        end
    end

    assign ex_md_en       = ex_en_q;
    assign ex_md_result   = ex_res_q;
    assign ex_md_dst_addr = ex_dst_q;
    assign ex_md_gpr_we_  = ex_we_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - self-checking bench for ex_muldiv with an arithmetic reference model
// The driver models the ID/EX slot: it advances to the next instruction only when md_stall is low.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_en;
    logic [2:0]  id_md_op;
    logic [31:0] id_md_in_0, id_md_in_1;
    logic [4:0]  id_dst_addr;
    logic        id_gpr_we_;
    logic        flush;
    logic        md_stall;
    logic        ex_md_en;
    logic [31:0] ex_md_result;
    logic [4:0]  ex_md_dst_addr;
    logic        ex_md_gpr_we_;

    always #5 clk = ~clk;

    ex_muldiv #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .id_en(id_en), .id_md_op(id_md_op),
        .id_md_in_0(id_md_in_0), .id_md_in_1(id_md_in_1),
        .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_), .flush(flush),
        .md_stall(md_stall), .ex_md_en(ex_md_en), .ex_md_result(ex_md_result),
        .ex_md_dst_addr(ex_md_dst_addr), .ex_md_gpr_we_(ex_md_gpr_we_)
    );

    int n_vec = 0;
    int n_err = 0;

    // Instruction program presented through the ID/EX slot
    int          p_n;
    logic [2:0]  p_op[8];
    logic [31:0] p_a[8], p_b[8];
    logic [4:0]  p_dst[8];
    logic        p_we[8];
    logic        p_en[8];
    int          flush_at;

    bit          stall_log[256];
    int          pl_cyc[$];
    logic [31:0] pl_res[$];
    logic [4:0]  pl_dst[$];
    logic        pl_we[$];

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            3'd1:    return p[31:0];
            3'd2:    return p[63:32];
            3'd3:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd4:    return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int count_stalls(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) n += stall_log[c];
        return n;
    endfunction

    task automatic present(input int k);
        if (k < p_n) begin
            id_en = p_en[k]; id_md_op = p_op[k]; id_md_in_0 = p_a[k]; id_md_in_1 = p_b[k];
            id_dst_addr = p_dst[k]; id_gpr_we_ = p_we[k];
        end else begin
            id_en = 1'b0; id_md_op = 3'd0; id_md_in_0 = $urandom; id_md_in_1 = $urandom;
            id_dst_addr = 5'($urandom); id_gpr_we_ = 1'b1;
        end
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic run_prog(input int cycles);
        int k;
        bit s;
        k = 0;
        pl_cyc.delete(); pl_res.delete(); pl_dst.delete(); pl_we.delete();
        for (int c = 0; c < cycles; c++) begin
            present(k);
            flush = (c == flush_at);
            @(negedge clk);
            s = (md_stall === 1'b1);
            stall_log[c] = s;
            if (ex_md_en !== 1'b0) begin
                pl_cyc.push_back(c); pl_res.push_back(ex_md_result);
                pl_dst.push_back(ex_md_dst_addr); pl_we.push_back(ex_md_gpr_we_);
            end
            @(posedge clk); #1;
            if (!s) k++;
        end
        flush = 1'b0;
        id_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; id_en = 1'b0; flush = 1'b0; id_md_op = 3'd0;
        id_md_in_0 = 0; id_md_in_1 = 0; id_dst_addr = 0; id_gpr_we_ = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (md_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %0b exp 0", md_stall); end
        n_vec++; if (ex_md_en !== 1'b0) begin n_err++; $display("FAIL reset_en got %0b exp 0", ex_md_en); end
        n_vec++; if (ex_md_gpr_we_ !== 1'b1) begin n_err++; $display("FAIL reset_we got %0b exp 1", ex_md_gpr_we_); end
        n_vec++; if (ex_md_dst_addr !== 5'd0) begin n_err++; $display("FAIL reset_dst got %0d exp 0", ex_md_dst_addr); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        // Start a DIVU, then reset in the cycle where the step counter reads 10.
        id_en = 1'b1; id_md_op = 3'd3; id_md_in_0 = 32'hDEAD_BEEF; id_md_in_1 = 32'd13;
        id_dst_addr = 5'd4; id_gpr_we_ = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b1; id_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (md_stall !== 1'b0) begin n_err++; $display("FAIL middiv_reset_stall got %0b exp 0", md_stall); end
        n_vec++; if (ex_md_en !== 1'b0) begin n_err++; $display("FAIL middiv_reset_en got %0b exp 0", ex_md_en); end
        n_vec++; if (ex_md_gpr_we_ !== 1'b1) begin n_err++; $display("FAIL middiv_reset_we got %0b exp 1", ex_md_gpr_we_); end
        n_vec++; if (ex_md_result !== 32'h0) begin n_err++; $display("FAIL middiv_reset_result got %h exp 0", ex_md_result); end
        @(posedge clk); #1;
        p_n = 0; flush_at = -1;
        run_prog(40);
        n_vec++; if (pl_cyc.size() != 0 || count_stalls(0, 39) != 0) begin
            n_err++; $display("FAIL middiv_reset_quiet got pulses=%0d stalls=%0d exp 0/0", pl_cyc.size(), count_stalls(0, 39));
        end
    endtask

    task automatic test_arith();
        logic [2:0]  t_op[16];
        logic [31:0] t_a[16], t_b[16];
        logic [31:0] exp_r;
        string       tag;
        int          n;
        t_op[0] = 3'd1; t_a[0] = 32'h0001_0003; t_b[0] = 32'h0002_0005;
        t_op[1] = 3'd2; t_a[1] = 32'hFFFF_FFFF; t_b[1] = 32'hFFFF_FFFF;
        t_op[2] = 3'd1; t_a[2] = 32'hFFFF_FFFF; t_b[2] = 32'hFFFF_FFFF;
        t_op[3] = 3'd3; t_a[3] = 32'd100;       t_b[3] = 32'd7;
        t_op[4] = 3'd4; t_a[4] = 32'd100;       t_b[4] = 32'd7;
        t_op[5] = 3'd3; t_a[5] = 32'h1234;      t_b[5] = 32'h0;
        t_op[6] = 3'd4; t_a[6] = 32'h1234;      t_b[6] = 32'h0;
        n = 7;
        for (int i = 0; i < 7; i++) begin
            t_op[n] = 3'($urandom_range(1, 4));
            t_a[n]  = $urandom;
            case ($urandom_range(0, 3))
                0:       t_b[n] = 32'h0;
                1:       t_b[n] = $urandom_range(1, 255);
                default: t_b[n] = $urandom;
            endcase
            n++;
        end
        for (int i = 0; i < n; i++) begin
            tag = $sformatf("arith%0d_op%0d", i, t_op[i]);
            p_n = 1; flush_at = -1;
            p_en[0] = 1'b1; p_op[0] = t_op[i]; p_a[0] = t_a[i]; p_b[0] = t_b[i];
            p_dst[0] = (i == 0) ? 5'd7 : 5'($urandom); p_we[0] = (i == 0) ? 1'b0 : 1'($urandom);
            exp_r = model(t_op[i], t_a[i], t_b[i]);
            run_prog(40);
            n_vec++; if (count_stalls(0, 39) != 33 || stall_log[33]) begin
                n_err++; $display("FAIL %s stall_cycles got %0d exp 33 (done stall %0b)", tag, count_stalls(0, 39), stall_log[33]);
            end
            n_vec++; if (pl_cyc.size() != 1) begin
                n_err++; $display("FAIL %s pulse_count got %0d exp 1", tag, pl_cyc.size());
            end else begin
                n_vec++; if (pl_cyc[0] != 34) begin n_err++; $display("FAIL %s pulse_cycle got %0d exp 34", tag, pl_cyc[0]); end
                n_vec++; if (pl_res[0] !== exp_r) begin n_err++; $display("FAIL %s result got %h exp %h", tag, pl_res[0], exp_r); end
                n_vec++; if (pl_dst[0] !== p_dst[0] || pl_we[0] !== p_we[0]) begin
                    n_err++; $display("FAIL %s dst_we got %0d/%0b exp %0d/%0b", tag, pl_dst[0], pl_we[0], p_dst[0], p_we[0]);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] exp_r;
        p_n = 2; flush_at = 6;
        p_en[0] = 1'b1; p_op[0] = 3'd3; p_a[0] = 32'd100; p_b[0] = 32'd7; p_dst[0] = 5'd2; p_we[0] = 1'b0;
        p_en[1] = 1'b1; p_op[1] = 3'd1; p_a[1] = $urandom; p_b[1] = $urandom; p_dst[1] = 5'd9; p_we[1] = 1'b0;
        exp_r = model(3'd1, p_a[1], p_b[1]);
        run_prog(46);
        n_vec++; if (!stall_log[5] || stall_log[6]) begin
            n_err++; $display("FAIL flush_stall got c5=%0b c6=%0b exp 1/0", stall_log[5], stall_log[6]);
        end
        n_vec++; if (count_stalls(7, 45) != 33) begin
            n_err++; $display("FAIL flush_next_stalls got %0d exp 33", count_stalls(7, 45));
        end
        n_vec++; if (pl_cyc.size() != 1) begin
            n_err++; $display("FAIL flush_pulse_count got %0d exp 1", pl_cyc.size());
        end else begin
            n_vec++; if (pl_cyc[0] != 41 || pl_res[0] !== exp_r || pl_dst[0] !== 5'd9) begin
                n_err++; $display("FAIL flush_next_result got c%0d %h d%0d exp c41 %h d9", pl_cyc[0], pl_res[0], pl_dst[0], exp_r);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e0, e1;
        p_n = 2; flush_at = -1;
        p_en[0] = 1'b1; p_op[0] = 3'd1; p_a[0] = $urandom; p_b[0] = $urandom; p_dst[0] = 5'd11; p_we[0] = 1'b0;
        p_en[1] = 1'b1; p_op[1] = 3'd3; p_a[1] = $urandom; p_b[1] = $urandom_range(1, 1000); p_dst[1] = 5'd12; p_we[1] = 1'b1;
        e0 = model(p_op[0], p_a[0], p_b[0]);
        e1 = model(p_op[1], p_a[1], p_b[1]);
        run_prog(72);
        n_vec++; if (count_stalls(0, 32) != 33 || stall_log[33] || !stall_log[34]) begin
            n_err++; $display("FAIL b2b_gap got first=%0d c33=%0b c34=%0b exp 33/0/1", count_stalls(0, 32), stall_log[33], stall_log[34]);
        end
        n_vec++; if (count_stalls(34, 71) != 33 || stall_log[67]) begin
            n_err++; $display("FAIL b2b_second_stalls got %0d c67=%0b exp 33/0", count_stalls(34, 71), stall_log[67]);
        end
        n_vec++; if (pl_cyc.size() != 2) begin
            n_err++; $display("FAIL b2b_pulse_count got %0d exp 2", pl_cyc.size());
        end else begin
            n_vec++; if (pl_cyc[0] != 34 || pl_res[0] !== e0 || pl_dst[0] !== 5'd11) begin
                n_err++; $display("FAIL b2b_first got c%0d %h d%0d exp c34 %h d11", pl_cyc[0], pl_res[0], pl_dst[0], e0);
            end
            n_vec++; if (pl_cyc[1] != 68 || pl_res[1] !== e1 || pl_dst[1] !== 5'd12 || pl_we[1] !== 1'b1) begin
                n_err++; $display("FAIL b2b_second got c%0d %h d%0d exp c68 %h d12", pl_cyc[1], pl_res[1], pl_dst[1], e1);
            end
        end
    endtask

    task automatic test_no_stall();
        logic [2:0] ops[3];
        logic       ens[3];
        ops[0] = 3'd1; ens[0] = 1'b0;
        ops[1] = 3'd5; ens[1] = 1'b1;
        ops[2] = 3'd0; ens[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p_n = 1; flush_at = -1;
            p_en[0] = ens[i]; p_op[0] = ops[i]; p_a[0] = $urandom; p_b[0] = $urandom;
            p_dst[0] = 5'd3; p_we[0] = 1'b0;
            run_prog(8);
            n_vec++; if (count_stalls(0, 7) != 0 || pl_cyc.size() != 0) begin
                n_err++; $display("FAIL nostall%0d got stalls=%0d pulses=%0d exp 0/0", i, count_stalls(0, 7), pl_cyc.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_flush();
        test_back_to_back();
        test_no_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Execute-side consumer of the ID/EX pipeline register for multi-cycle unsigned multiply and divide.
- Latches a mul/div operation from the ID/EX bundle and iterates it over 32 cycles.
- Holds the ID/EX register frozen via md_stall while busy.
- Presents the result as its own EX/MEM-side register bundle.

Parameters:
- DATA_W, 32, operand/result width. Iteration count equals DATA_W.
- ADDR_W, 5, GPR address width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous and active-high
- id_en  in  1  ID/EX bundle valid
- id_md_op  in  3  0=NOP, 1=MUL (low product), 2=MULHU (high product), 3=DIVU, 4=REMU; 5-7 treated as NOP
- id_md_in_0  in  DATA_W  multiplicand / dividend
- id_md_in_1  in  DATA_W  multiplier / divisor
- id_dst_addr  in  ADDR_W  destination GPR
- id_gpr_we_  in  1  GPR write enable, active-low
- flush  in  1  pipeline flush from control
- md_stall  out  1  stall request to IF/ID/ID-EX registers; combinational
- ex_md_en  out  1  result bundle valid
- ex_md_result  out  DATA_W  result
- ex_md_dst_addr  out  ADDR_W  destination GPR
- ex_md_gpr_we_  out  1  GPR write enable, active-low

Behaviour:
- States:
  - IDLE, MUL, DIV, DONE.
  - 6-bit step counter.
  - Operand and op/dst/we_ latches.
  - 2*DATA_W accumulator for MUL.
  - DATA_W+1 remainder and DATA_W quotient for DIV.
- Reset (synchronous, reset=1 at posedge):
  - State IDLE, counter 0.
  - ex_md_en=0, ex_md_result=0, ex_md_dst_addr=0, ex_md_gpr_we_=1.
  - Reset overrides flush and any in-flight operation.
- Accept condition: IDLE && id_en=1 && op in {1..4} && flush=0.
  - Next state is MUL for op 1/2, DIV for op 3/4.
  - Latch operands, op, dst, we_; clear counter.
- md_stall:
  - 1 when the accept condition holds, or state is MUL/DIV with flush=0.
  - 0 in IDLE-without-accept and in DONE.
  - Forced 0 whenever flush=1.
- MUL:
  - Radix-2 shift-add, one multiplier bit per cycle, LSB first.
  - After step DATA_W-1, go to DONE.
  - MUL returns product[DATA_W-1:0]; MULHU returns product[2*DATA_W-1:DATA_W].
- DIV:
  - Restoring division, one quotient bit per cycle, MSB first.
  - After step DATA_W-1, go to DONE.
  - Divide by zero still runs the full 32 cycles: DIVU=all ones, REMU=dividend.
- DONE:
  - md_stall=0, so the ID/EX register advances this edge.
  - At this edge: ex_md_en=1, ex_md_result=selected result, ex_md_dst_addr/ex_md_gpr_we_ from the latches. Next state IDLE.
  - The instruction that just completed has left ID/EX by the next cycle, so it cannot be re-accepted.
- ex_md_* outside a DONE edge:
  - ex_md_en=0, result=0, dst=0, we_=1.
  - The bundle is valid for exactly one cycle.
- Latency:
  - Accept in cycle T (md_stall=1).
  - T+1..T+32 busy (md_stall=1); T+33 DONE (md_stall=0).
  - ex_md_en=1 during T+34.
  - Total stall: 33 cycles.
- Flush:
  - In IDLE: no accept.
  - In MUL/DIV/DONE: abort to IDLE, discard latches, ex_md_en=0 at that edge.
  - Takes effect the same cycle, with md_stall=0 in that cycle.
- id_en=0, or op NOP/5-7 in IDLE: no action, md_stall=0.
- Inputs are ignored while busy; the pipeline is held by md_stall.

Test Plan:
- Reset asserted mid-DIV (counter=10) → next cycle: IDLE, md_stall=0, ex_md_en=0, ex_md_gpr_we_=1, ex_md_result=0.
- MUL 0x0001_0003 × 0x0002_0005, dst=7, we_=0 → md_stall high 33 cycles; ex_md_en=1 for 1 cycle at T+34 with result=0x000B_000F, dst=7, we_=0.
- MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → result 0xFFFF_FFFE. MUL with the same operands → 0x0000_0001.
- DIVU 100/7 → 14; REMU 100/7 → 2. DIVU 0x1234/0 → 0xFFFF_FFFF; REMU 0x1234/0 → 0x0000_1234. Each takes exactly 33 stall cycles.
- Flush at busy step 5 of a DIVU → md_stall=0 that cycle, IDLE next, no ex_md_en pulse. A MUL presented afterwards is accepted normally.
- Back-to-back MUL then DIVU in consecutive ID/EX slots → two separate 33-cycle stalls and two single-cycle ex_md_en pulses. There is exactly one IDLE accept cycle between them, and the first op is never re-executed. id_en=0 with op=MUL → no stall.
